hit_miss_merge_buffer: RTL

HIT_MISS_MERGE_BUFFER -- requirements
Module: hit_miss_merge_buffer

---
 rtl/hit_miss_merge_buffer_pkg.sv | 22 ++
 rtl/hit_miss_merge_buffer.sv | 88 ++++++++
 2 files changed

// File: rtl/hit_miss_merge_buffer_pkg.sv
// Shared LLC types: descriptor carried down the tag-lookup delay line and the
// tag-lookup result that gets merged with it.
package hit_miss_merge_buffer_pkg;

  localparam int MaxEntries = 8;
  localparam int LlcWays    = 8;
  localparam int WayW       = $clog2(LlcWays);

  typedef struct packed {
    logic [3:0]  req_id;
    logic [25:0] line_addr;
    logic        is_write;
  } llc_desc_t;

  typedef struct packed {
    logic            hit;
    logic [WayW-1:0] way;
    logic            dirty;
    logic            evict;
  } llc_tag_res_t;

endpackage

// File: rtl/hit_miss_merge_buffer.sv
// Small FIFO that joins each delay-line descriptor with its tag-lookup result
// and holds the pair until downstream accepts it.
module hit_miss_merge_buffer #(
  parameter int  NumEntries = 2,
  parameter type desc_t     = logic,
  parameter type tag_res_t  = logic
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     desc_valid_i,
  input  desc_t    desc_i,
  input  logic     pipe_busy_i,
  output logic     shift_en_o,
  input  logic     tag_valid_i,
  input  tag_res_t tag_res_i,
  output logic     valid_o,
  input  logic     ready_i,
  output desc_t    desc_o,
  output tag_res_t tag_res_o,
  output logic     idle_o,
  output logic     align_err_o
);
  import hit_miss_merge_buffer_pkg::*;

  localparam int CntW = $clog2(NumEntries + 1);
  localparam int PtrW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(NumEntries);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NumEntries - 1);

  if (NumEntries < 1 || NumEntries > MaxEntries) begin : g_bad_depth
    $error("hit_miss_merge_buffer: NumEntries must be in 1..%0d", MaxEntries);
  end

  logic [CntW-1:0] count;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  desc_t           desc_mem [NumEntries];
  tag_res_t        tag_mem  [NumEntries];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic orphan_tag;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full       = (count == FullCnt);
  assign empty      = (count == '0);
  assign shift_en_o = ~full | ready_i;
  assign push       = desc_valid_i & shift_en_o;
  assign valid_o    = ~empty;
  assign pop        = valid_o & ready_i;
  assign orphan_tag = tag_valid_i & ~desc_valid_i & shift_en_o;
  assign idle_o     = empty & ~pipe_busy_i & ~desc_valid_i;

  assign desc_o    = desc_mem[rd_ptr];
  assign tag_res_o = tag_mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      align_err_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if ((push & ~tag_valid_i) | orphan_tag) align_err_o <= 1'b1;
    end
  end

  // Storage has no reset and only loads on push, so it can sit behind a clock gate.
  always_ff @(posedge clk_i) begin
    if (push) begin
      desc_mem[wr_ptr] <= desc_i;
      tag_mem[wr_ptr]  <= tag_res_i;
    end
  end

endmodule
